fetch_icache_pipe: RTL and testbench
====================================

// Module: fetch_icache_pipe
// PURPOSE
//  Parametrised IF stage: PC register, direct-mapped instruction cache, refill FSM.
//  Sits between the branch-resolve logic (PCSrc/addr_branch) and the IF/ID register.
//  - Cache hit: one instruction per cycle.
//  - Miss: the line is refilled word by word from instruction memory over a req/ack handshake.
// PARAMETERS
//  ADDR_W          32  address width in bits
//  DATA_W          32  instruction width in bits
//  LINES           16  cache lines; power of 2, >=2
//  WORDS_PER_LINE   4  words per line; power of 2, >=1
//  RESET_PC         0  PC value after reset
// PORTS
//  clk              in   1       rising-edge clock
//  reset            in   1       asynchronous, active-low reset
//  stall            in   1       hold PC and all IF/ID outputs
//  PCSrc            in   1       redirect PC to addr_branch
//  addr_branch      in   ADDR_W  redirect target, word aligned
//  mem_req          out  1       refill read request
//  mem_addr         out  ADDR_W  refill word address
//  mem_ack          in   1       mem_rdata valid for the current mem_addr
//  mem_rdata        in   DATA_W  refill data
//  valid_out        out  1       instruction_out/addr_out carry a real instruction
//  hit_out          out  1       delivered instruction came from a cache hit
//  addr_out         out  ADDR_W  PC+4 of the delivered instruction
//  instruction_out  out  DATA_W  fetched instruction
// BEHAVIOUR
//  Reset values (asynchronous; reset low clears everything, including mid-refill):
//   pc=RESET_PC; all valid bits=0; state=RUN; mem_req=0; mem_addr=0;
//   valid_out=0; hit_out=0; addr_out=0; instruction_out=0.
//  Address split:
//   pc[1:0] ignored; offset=pc[2+:OFF_W]; index=pc[2+OFF_W+:IDX_W]; tag=remaining upper bits.
//   OFF_W=log2(WORDS_PER_LINE); IDX_W=log2(LINES).
//  State RUN, evaluated in priority order:
//   - PCSrc: pc<=addr_branch; valid_out<=0. Always a one-cycle bubble; overrides stall.
//   - stall: pc and all outputs hold.
//   - hit: instruction_out<=line word; addr_out<=pc+4; valid_out<=1; hit_out<=1; pc<=pc+4.
//     Hit latency is 1 cycle.
//   - miss: valid_out<=0; hit_out<=0; base<=pc with offset bits cleared; cnt<=0; go REFILL.
//  State REFILL:
//   - mem_req=1; mem_addr=base+4*cnt, held stable until mem_ack is sampled high.
//   - On each ack: store mem_rdata in word cnt; cnt++.
//   - On the last ack: set tag and valid bit for the line; go RUN. Next cycle the
//     (possibly redirected) pc is looked up and normally hits.
//   - Outputs: valid_out=0 throughout; stall is ignored, so the refill continues.
//   - PCSrc during REFILL: target latched into a pending-redirect register; the last
//     assertion wins. The refill is never abandoned. On return to RUN, pc<=pending target.
//  Handshake:
//   - mem_ack is ignored while mem_req=0.
//   - Back-to-back acks are allowed: one word per cycle.
//  Arithmetic:
//   - pc+4 wraps modulo 2^ADDR_W.
//   - A line whose refill completes always replaces the previous tag (eviction, no write-back).
//  Boundary cases:
//   - PCSrc and miss in the same RUN cycle: redirect wins, no refill starts.
//   - PCSrc in the cycle of the last ack: it becomes the pending target and is applied.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
//   - hit_count increments on every RUN hit that delivers an instruction.
//   - miss_count increments on every RUN->REFILL transition.
//   - Both saturate at 0xFFFFFFFF.
//  FETCH_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING (defaults; memory returns data = address ^ 0xA5A5A5A5; ack every cycle unless noted)
//  1. Reset low 20 ns, then release.
//     -> mem_addr 0x0,0x4,0x8,0xC.
//     -> 2 cycles after the 4th ack: valid_out=1, instruction_out=0xA5A5A5A5, addr_out=0x4.
//     -> Then addr_out 0x8,0xC,0x10 on consecutive cycles, hit_out=1.
//  2. Line 0 cached; pulse PCSrc=1 with addr_branch=0x8.
//     -> Exactly 1 bubble (valid_out=0).
//     -> Then instruction_out=0xA5A5A5AD, addr_out=0xC.
//  3. PCSrc=1, addr_branch=0x40 during the 2nd word of a refill of 0x10.
//     -> Refill of 0x10..0x1C completes.
//     -> Then a miss refills 0x40..0x4C; the first delivered addr_out=0x44.
//  4. stall=1 for 3 cycles in RUN -> outputs and pc constant.
//     mem_ack delayed 2 cycles -> mem_addr and mem_req stay stable until the ack.
//  5. Fetch 0x0, then redirect to 0x100 (same index, different tag) -> miss and refill.
//     Redirect back to 0x0 -> miss again (eviction). With FETCH_PERF_CNT_EN: miss_count=3.
//  6. Assert reset during REFILL -> mem_req=0 immediately.
//     After release, fetch of 0x0 misses again: all valid bits were cleared.

Source files
------------

// File: rtl/fetch_icache_pipe.sv
// IF stage: PC register, direct-mapped instruction cache and a word-by-word refill FSM.
// Optional hit/miss counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_icache_pipe #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                LINES          = 16,
    parameter int                WORDS_PER_LINE = 4,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] addr_branch,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              valid_out,
    output logic              hit_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] instruction_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int WI_W    = OFF_W + IDX_W;
    localparam int TAG_LSB = 2 + WI_W;
    localparam int CNT_W   = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4 * WORDS_PER_LINE - 1);

    typedef enum logic {S_RUN, S_REFILL} state_t;

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_pc;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_pend_v;
    logic [ADDR_W-1:0]         r_pend_addr;
    logic                      r_mem_req;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic                      r_valid_out;
    logic                      r_hit_out;
    logic [ADDR_W-1:0]         r_addr_out;
    logic [DATA_W-1:0]         r_instr;
    logic [LINES-1:0]          r_valid;
    logic [ADDR_W-TAG_LSB-1:0] r_tag  [LINES];
    logic [DATA_W-1:0]         r_data [LINES*WORDS_PER_LINE];

    // Lookup side: index and word offset are contiguous, so one slice addresses the data array.
    logic [IDX_W-1:0]          w_idx;
    logic [WI_W-1:0]           w_word;
    logic [ADDR_W-TAG_LSB-1:0] w_tag;
    logic                      w_hit;
    assign w_idx  = r_pc[2+OFF_W +: IDX_W];
    assign w_word = r_pc[2 +: WI_W];
    assign w_tag  = r_pc[ADDR_W-1:TAG_LSB];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Refill side: the request address already points at the word being filled.
    logic [IDX_W-1:0]          w_fill_idx;
    logic [WI_W-1:0]           w_fill_word;
    logic                      w_ack;
    logic                      w_last;
    assign w_fill_idx  = r_mem_addr[2+OFF_W +: IDX_W];
    assign w_fill_word = r_mem_addr[2 +: WI_W];
    assign w_ack       = (r_state == S_REFILL) && mem_ack;
    assign w_last      = w_ack && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (w_ack) begin
            r_data[w_fill_word] <= mem_rdata;
        end
        if (w_last) begin
            r_tag[w_fill_idx] <= r_mem_addr[ADDR_W-1:TAG_LSB];
        end
    end

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_valid[gi] <= 1'b0;
                end else if (w_last && (w_fill_idx == IDX_W'(gi))) begin
                    r_valid[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_cnt       <= '0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_valid_out <= 1'b0;
            r_hit_out   <= 1'b0;
            r_addr_out  <= '0;
            r_instr     <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (PCSrc) begin
                        r_pc        <= addr_branch;
                        r_valid_out <= 1'b0;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (w_hit) begin
                        r_instr     <= r_data[w_word];
                        r_addr_out  <= r_pc + ADDR_W'(4);
                        r_valid_out <= 1'b1;
                        r_hit_out   <= 1'b1;
                        r_pc        <= r_pc + ADDR_W'(4);
                    end else begin
                        r_valid_out <= 1'b0;
                        r_hit_out   <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= r_pc & LINE_MASK;
                        r_cnt       <= '0;
                        r_pend_v    <= 1'b0;
                        r_state     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    // Redirects never abort a refill; the newest one is replayed afterwards.
                    if (PCSrc) begin
                        r_pend_v    <= 1'b1;
                        r_pend_addr <= addr_branch;
                    end
                    if (w_ack) begin
                        if (r_cnt == CNT_LAST) begin
                            r_mem_req <= 1'b0;
                            r_pend_v  <= 1'b0;
                            r_state   <= S_RUN;
                            if (PCSrc) begin
                                r_pc <= addr_branch;
                            end else if (r_pend_v) begin
                                r_pc <= r_pend_addr;
                            end
                        end else begin
                            r_cnt      <= r_cnt + CNT_W'(1);
                            r_mem_addr <= r_mem_addr + ADDR_W'(4);
                        end
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        w_run_go;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    assign w_run_go = (r_state == S_RUN) && !PCSrc && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_run_go) begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (!w_hit && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

    assign mem_req         = r_mem_req;
    assign mem_addr        = r_mem_addr;
    assign valid_out       = r_valid_out;
    assign hit_out         = r_hit_out;
    assign addr_out        = r_addr_out;
    assign instruction_out = r_instr;

endmodule

// File: tb/tb_fetch_icache_pipe.sv
// Bench for fetch_icache_pipe: directed scenarios plus randomized redirects/stalls/ack timing,
// checked every cycle against a line-set model of the cache and the PC stream.
module tb_fetch_icache_pipe;

    localparam int          LINES = 16;
    localparam int          WPL   = 4;
    localparam logic [31:0] PAT   = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] addr_branch = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        valid_out;
    logic        hit_out;
    logic [31:0] addr_out;
    logic [31:0] instruction_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    // Instruction memory content is a pure function of the address.
    assign mem_rdata = mem_addr ^ PAT;

    fetch_icache_pipe dut (
        .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc), .addr_branch(addr_branch),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .valid_out(valid_out), .hit_out(hit_out), .addr_out(addr_out),
        .instruction_out(instruction_out)
`ifdef FETCH_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: which memory line each cache slot holds, the next PC to deliver, refill progress.
    bit          m_lv  [LINES];
    int unsigned m_lno [LINES];
    logic [31:0] m_pc, m_base, m_pend;
    bit          m_ref, m_pend_v;
    int          m_cnt;
    bit          e_vo, e_ho;
    logic [31:0] e_ao, e_io;

    function automatic bit cached(input logic [31:0] a);
        int unsigned ln;
        ln = a / (4 * WPL);
        return m_lv[ln % LINES] && (m_lno[ln % LINES] == ln);
    endfunction

    // Transaction logs used by the directed checks.
    logic [31:0] aq[$], dq[$], dqi[$];
    int          aqe[$], dqe[$];
    int          edge_n = 0;
    int          nref = 0;

    logic        s_pcsrc, s_stall, s_ack, s_rst, s_req;
    logic [31:0] s_ab, s_ma;
    bit          dlv;

    always begin
        @(posedge clk);
        s_pcsrc = PCSrc; s_stall = stall; s_ab = addr_branch; s_ack = mem_ack;
        s_rst = reset; s_req = mem_req; s_ma = mem_addr;
        #1;
        edge_n++;
        dlv = 1'b0;
        if (!s_rst) begin
            for (int i = 0; i < LINES; i++) m_lv[i] = 1'b0;
            m_pc = 32'h0; m_ref = 1'b0; m_pend_v = 1'b0; m_cnt = 0; m_base = 32'h0;
            e_vo = 1'b0; e_ho = 1'b0; e_ao = 32'h0; e_io = 32'h0;
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_hit_out", hit_out, 32'h0);
        end else begin
            if (!s_req && mem_req) nref++;
            if (!m_ref) begin
                if (s_pcsrc) begin
                    m_pc = s_ab;
                    e_vo = 1'b0;
                end else if (!s_stall) begin
                    if (cached(m_pc)) begin
                        e_vo = 1'b1; e_ho = 1'b1;
                        e_ao = m_pc + 32'd4;
                        e_io = m_pc ^ PAT;
                        m_pc = m_pc + 32'd4;
                        dlv  = 1'b1;
                    end else begin
                        e_vo = 1'b0; e_ho = 1'b0;
                        m_ref = 1'b1; m_pend_v = 1'b0; m_cnt = 0;
                        m_base = m_pc - (m_pc % (4 * WPL));
                    end
                end
            end else begin
                if (s_pcsrc) begin
                    m_pend_v = 1'b1;
                    m_pend   = s_ab;
                end
                if (s_ack) begin
                    aq.push_back(s_ma);
                    aqe.push_back(edge_n);
                    m_cnt++;
                    if (m_cnt == WPL) begin
                        m_lv[(m_base / (4 * WPL)) % LINES]  = 1'b1;
                        m_lno[(m_base / (4 * WPL)) % LINES] = m_base / (4 * WPL);
                        m_ref = 1'b0;
                        if (m_pend_v) m_pc = m_pend;
                        m_pend_v = 1'b0;
                    end
                end
            end
        end
        chk("valid_out", valid_out, e_vo);
        chk("mem_req", mem_req, m_ref);
        if (m_ref) chk("mem_addr", mem_addr, m_base + 32'(4 * m_cnt));
        chk("addr_out", addr_out, e_ao);
        chk("instruction_out", instruction_out, e_io);
        if (e_vo) chk("hit_out", hit_out, 32'h1);
        if (dlv) begin
            dq.push_back(addr_out);
            dqi.push_back(instruction_out);
            dqe.push_back(edge_n);
            $display("deliver edge=%0d addr_out=0x%08h instr=0x%08h", edge_n, addr_out, instruction_out);
        end
    end

    // Memory responder: fixed ack delay or random acks; random noise on mem_ack while idle.
    int ack_delay = 0;
    bit ack_rand = 1'b0;
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (ack_rand) begin
                    mem_ack = ($urandom_range(0, 2) != 0);
                end else if (wcnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                wcnt = 0;
            end
        end
    end

    task automatic wait_dq(input int n, input string nm);
        int k;
        k = 0;
        while (dq.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(dq.size() >= n), 32'h1);
    endtask

    task automatic wait_aq(input int n, input string nm);
        int k;
        k = 0;
        while (aq.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(aq.size() >= n), 32'h1);
    endtask

    task automatic redirect(input logic [31:0] a);
        PCSrc = 1'b1;
        addr_branch = a;
        @(negedge clk);
        PCSrc = 1'b0;
    endtask

    logic [31:0] exp3 [8] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h40, 32'h44, 32'h48, 32'h4C};
    logic [31:0] exp1 [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Cold start: refill line 0, then stream hits.
        wait_dq(4, "t1_deliver_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("t1_mem_addr", aq[i], exp1[i]);
            chk("t1_addr_out", dq[i], exp1[i] + 32'd4);
        end
        chk("t1_first_instr", dqi[0], 32'hA5A5A5A5);
        // Ack high in cycle k, instruction visible in cycle k+2: one edge apart.
        chk("t1_latency", 32'(dqe[0] - aqe[3]), 32'd1);

        // Redirect coinciding with a miss on 0x10: redirect wins, one bubble.
        PCSrc = 1'b1;
        addr_branch = 32'h8;
        @(negedge clk);
        PCSrc = 1'b0;
        chk("t2_bubble", valid_out, 32'h0);
        chk("t2_no_refill", mem_req, 32'h0);
        @(negedge clk);
        chk("t2_valid", valid_out, 32'h1);
        chk("t2_instr", instruction_out, 32'hA5A5A5AD);
        chk("t2_addr", addr_out, 32'hC);

        // Redirect during the second word of the 0x10 refill.
        aq.delete(); aqe.delete();
        wait_aq(1, "t3_first_ack_timeout");
        dq.delete(); dqi.delete(); dqe.delete();
        redirect(32'h40);
        wait_dq(1, "t3_deliver_timeout");
        chk("t3_first_addr", dq[0], 32'h44);
        for (int i = 0; i < 8; i++) chk("t3_refill_addr", aq[i], exp3[i]);

        // Stall in RUN holds everything; then a slow-ack refill.
        stall = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_stall_addr", addr_out, 32'h44);
        chk("t4_stall_valid", valid_out, 32'h1);
        stall = 1'b0;
        ack_delay = 2;
        aq.delete(); aqe.delete(); dq.delete(); dqi.delete(); dqe.delete();
        redirect(32'h80);
        wait_dq(1, "t4_deliver_timeout");
        chk("t4_ack_spacing", 32'(aqe[1] - aqe[0]), 32'd3);
        chk("t4_first_addr", dq[0], 32'h84);
        ack_delay = 0;

        // Address wrap past the top of the space.
        dq.delete(); dqi.delete(); dqe.delete();
        redirect(32'hFFFF_FFF8);
        wait_dq(2, "wrap_timeout");
        chk("wrap_addr0", dq[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", dq[1], 32'h0);

        // Reset asserted in the middle of a refill.
        aq.delete(); aqe.delete();
        redirect(32'h200);
        wait_aq(1, "t6_ack_timeout");
        reset = 1'b0;
        #1;
        chk("t6_req_drop", mem_req, 32'h0);
        chk("t6_valid_drop", valid_out, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        aq.delete(); aqe.delete(); dq.delete(); dqi.delete(); dqe.delete();
        nref = 0;

        // Eviction: 0x0 and 0x100 share an index.
        wait_dq(1, "t5_a_timeout");
        chk("t6_refetch_miss", aq[0], 32'h0);
        chk("t5_a_addr", dq[0], 32'h4);
        dq.delete(); dqi.delete(); dqe.delete();
        redirect(32'h100);
        wait_dq(1, "t5_b_timeout");
        chk("t5_b_addr", dq[0], 32'h104);
        dq.delete(); dqi.delete(); dqe.delete();
        redirect(32'h0);
        wait_dq(1, "t5_c_timeout");
        chk("t5_c_addr", dq[0], 32'h4);
        chk("t5_refills", nref, 32'd3);
`ifdef FETCH_PERF_CNT_EN
        chk("t5_miss_count", miss_count, 32'd3);
`endif

        // Randomized redirects, stalls and ack timing.
        ack_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            PCSrc = ($urandom_range(0, 11) == 0);
            stall = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0)
                addr_branch = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7) * 4);
            else
                addr_branch = 32'($urandom_range(0, 3) * 256 + $urandom_range(0, 63) * 4);
        end
        PCSrc = 1'b0;
        stall = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
